flash_cmd_seq: RTL and testbench



---
 rtl/flash_seq_pkg.sv | 96 +++++++++
 rtl/flash_cmd_seq_if.sv | 36 +++
 rtl/flash_bus_cycle.sv | 109 ++++++++++
 rtl/flash_cmd_seq.sv | 106 ++++++++++
 tb/tb_flash_cmd_seq.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_seq_pkg.sv
// Shared definitions for the parallel-flash command sequencer: command
// encodings, FSM states, JEDEC command bytes and unlock addresses, and the
// step table that turns (command, step index) into one bus cycle.
package flash_seq_pkg;

    typedef enum logic [1:0] {
        CMD_READ         = 2'b00,
        CMD_PROGRAM      = 2'b01,
        CMD_SECTOR_ERASE = 2'b10,
        CMD_RESET        = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WE_PULSE = 3'd2,
        ST_HOLD     = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RECOVER  = 3'd5
    } state_t;

    // JEDEC command bytes (zero-extended to DATA_W at the top level)
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_55 = 8'h55;
    localparam logic [7:0] BYTE_A0 = 8'hA0;
    localparam logic [7:0] BYTE_80 = 8'h80;
    localparam logic [7:0] BYTE_30 = 8'h30;
    localparam logic [7:0] BYTE_F0 = 8'hF0;

    // Unlock addresses (zero-extended to ADDR_W at the top level)
    localparam logic [11:0] ADDR_555 = 12'h555;
    localparam logic [11:0] ADDR_2AA = 12'h2AA;
    localparam logic [11:0] ADDR_000 = 12'h000;

    // Number of bus cycles per command
    localparam int READ_STEPS    = 1;
    localparam int PROGRAM_STEPS = 4;
    localparam int ERASE_STEPS   = 6;
    localparam int RESET_STEPS   = 1;
    localparam int IDX_W         = 3;

    // One table entry; use_tgt_* substitute the latched target address/data
    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
        logic        use_tgt_addr;
        logic        use_tgt_data;
        logic        is_read;
        logic        is_last;
    } step_t;

    function automatic logic [IDX_W-1:0] step_count(cmd_e c);
        case (c)
            CMD_READ:         return IDX_W'(READ_STEPS);
            CMD_PROGRAM:      return IDX_W'(PROGRAM_STEPS);
            CMD_SECTOR_ERASE: return IDX_W'(ERASE_STEPS);
            default:          return IDX_W'(RESET_STEPS);
        endcase
    endfunction

    function automatic step_t step_lookup(cmd_e c, logic [IDX_W-1:0] idx);
        step_t s;
        s = '0;
        case (c)
            CMD_READ: begin
                s.use_tgt_addr = 1'b1;
                s.is_read      = 1'b1;
            end
            CMD_PROGRAM: begin
                case (idx)
                    3'd0:    begin s.addr = ADDR_555; s.data = BYTE_AA; end
                    3'd1:    begin s.addr = ADDR_2AA; s.data = BYTE_55; end
                    3'd2:    begin s.addr = ADDR_555; s.data = BYTE_A0; end
                    default: begin s.use_tgt_addr = 1'b1; s.use_tgt_data = 1'b1; end
                endcase
            end
            CMD_SECTOR_ERASE: begin
                case (idx)
                    3'd0:    begin s.addr = ADDR_555; s.data = BYTE_AA; end
                    3'd1:    begin s.addr = ADDR_2AA; s.data = BYTE_55; end
                    3'd2:    begin s.addr = ADDR_555; s.data = BYTE_80; end
                    3'd3:    begin s.addr = ADDR_555; s.data = BYTE_AA; end
                    3'd4:    begin s.addr = ADDR_2AA; s.data = BYTE_55; end
                    default: begin s.use_tgt_addr = 1'b1; s.data = BYTE_30; end
                endcase
            end
            default: begin
                s.addr = ADDR_000;
                s.data = BYTE_F0;
            end
        endcase
        s.is_last = (idx == (step_count(c) - IDX_W'(1)));
        return s;
    endfunction

endpackage

// File: rtl/flash_cmd_seq_if.sv
// Command and flash-bus signal bundle for flash_cmd_seq.
// Handshake: a command is accepted on the rising edge where start=1 and
// busy=0; busy acts as the inverse of ready. start while busy=1 is dropped,
// never queued. done pulses for one cycle when the sequence completes, and
// in that same cycle busy=0 so a new start is accepted with no gap.
interface flash_cmd_seq_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] shiftRegOut;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;
    logic              CE_N;
    logic              WE_N;
    logic              OE_N;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] DInDOut;
    logic              dq_oe;
    logic [DATA_W-1:0] shiftRegIn;

    // Sequencer side
    modport master (
        input  start, cmd, addr, shiftRegOut, data_out,
        output busy, done, CE_N, WE_N, OE_N, mem_addr, DInDOut, dq_oe, shiftRegIn
    );

    // Requester / flash side
    modport slave (
        output start, cmd, addr, shiftRegOut, data_out,
        input  busy, done, CE_N, WE_N, OE_N, mem_addr, DInDOut, dq_oe, shiftRegIn
    );
endinterface

// File: rtl/flash_bus_cycle.sv
// Runs one flash bus cycle (write: SETUP/WE_PULSE/HOLD/RECOVER, read:
// SETUP/RD_WAIT/RECOVER). All strobes are registered from the next state so
// they never glitch. A go in IDLE or RECOVER loads the next step.
module flash_bus_cycle
    import flash_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int WE_CYC = 2,
    parameter int RD_CYC = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [ADDR_W-1:0] step_addr,
    input  logic [DATA_W-1:0] step_data,
    input  logic              step_is_read,
    output logic              ce_n,
    output logic              we_n,
    output logic              oe_n,
    output logic              dq_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] wdata,
    output logic              rd_capture,
    output logic              cyc_end,
    output state_t            state
);
    localparam int MAX_CYC = (WE_CYC > RD_CYC) ? WE_CYC : RD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_nxt, load;
    logic             ce_n_d, we_n_d, oe_n_d, dq_oe_d;

    // Next state, wait counter and next strobe values
    always_comb begin
        st_d  = st_q;
        cnt_d = '0;
        load  = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (go) begin
                    st_d = ST_SETUP;
                    load = 1'b1;
                end
            end
            ST_SETUP: st_d = rd_q ? ST_RD_WAIT : ST_WE_PULSE;
            ST_WE_PULSE: begin
                if (cnt_q == CNT_W'(WE_CYC - 1)) st_d = ST_HOLD;
                else                             cnt_d = cnt_q + CNT_W'(1);
            end
            ST_HOLD: st_d = ST_RECOVER;
            ST_RD_WAIT: begin
                if (cnt_q == CNT_W'(RD_CYC - 1)) st_d = ST_RECOVER;
                else                             cnt_d = cnt_q + CNT_W'(1);
            end
            ST_RECOVER: begin
                if (go) begin
                    st_d = ST_SETUP;
                    load = 1'b1;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase

        rd_nxt  = load ? step_is_read : rd_q;
        ce_n_d  = !(st_d == ST_SETUP || st_d == ST_WE_PULSE ||
                    st_d == ST_HOLD  || st_d == ST_RD_WAIT);
        we_n_d  = !(st_d == ST_WE_PULSE);
        oe_n_d  = !(rd_nxt && (st_d == ST_SETUP || st_d == ST_RD_WAIT));
        dq_oe_d = !rd_nxt && (st_d == ST_SETUP || st_d == ST_WE_PULSE ||
                              st_d == ST_HOLD);
    end

    // State, counter, step latches and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            mem_addr <= '0;
            wdata    <= '0;
            ce_n     <= 1'b1;
            we_n     <= 1'b1;
            oe_n     <= 1'b1;
            dq_oe    <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            rd_q  <= rd_nxt;
            if (load) begin
                mem_addr <= step_addr;
                if (!step_is_read) wdata <= step_data;
            end
            ce_n  <= ce_n_d;
            we_n  <= we_n_d;
            oe_n  <= oe_n_d;
            dq_oe <= dq_oe_d;
        end
    end

    assign rd_capture = (st_q == ST_RD_WAIT) && (cnt_q == CNT_W'(RD_CYC - 1));
    assign cyc_end    = (st_q == ST_RECOVER);
    assign state      = st_q;

endmodule

// File: rtl/flash_cmd_seq.sv
// Parallel-flash command sequencer. Latches a command at accept, walks the
// step table one bus cycle at a time and pulses done after the last
// RECOVER. Read data is captured on the last RD_WAIT edge.
module flash_cmd_seq
    import flash_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int WE_CYC = 2,
    parameter int RD_CYC = 3
) (
    input  logic            SCL,
    input  logic            reset,
    flash_cmd_seq_if.master bus,
    output state_t          dbg_state
);
    cmd_e              cmd_q, cmd_sel;
    logic [ADDR_W-1:0] addr_q, addr_sel, step_addr;
    logic [DATA_W-1:0] wdata_q, data_sel, step_data;
    logic [IDX_W-1:0]  idx_q, idx_sel;
    logic              last_q, busy_q, done_q;
    logic [DATA_W-1:0] rdata_q;
    step_t             step;
    logic              accept, go;
    logic              cyc_end, rd_capture;
    logic              ce_n, we_n, oe_n, dq_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] wdata;

    // Select the step to load next: step 0 of the incoming command on
    // accept, otherwise the following step of the latched command.
    always_comb begin
        accept    = bus.start && !busy_q;
        cmd_sel   = accept ? cmd_e'(bus.cmd) : cmd_q;
        addr_sel  = accept ? bus.addr : addr_q;
        data_sel  = accept ? bus.shiftRegOut : wdata_q;
        idx_sel   = accept ? '0 : idx_q + IDX_W'(1);
        step      = step_lookup(cmd_sel, idx_sel);
        step_addr = step.use_tgt_addr ? addr_sel : ADDR_W'(step.addr);
        step_data = step.use_tgt_data ? data_sel : DATA_W'(step.data);
        go        = accept || (cyc_end && !last_q);
    end

    // Command latches, step index, busy/done and read capture
    always_ff @(posedge SCL or negedge reset) begin
        if (!reset) begin
            cmd_q   <= CMD_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= cyc_end && last_q;
            if (accept) begin
                busy_q  <= 1'b1;
                cmd_q   <= cmd_e'(bus.cmd);
                addr_q  <= bus.addr;
                wdata_q <= bus.shiftRegOut;
            end else if (cyc_end && last_q) begin
                busy_q <= 1'b0;
            end
            if (go) begin
                idx_q  <= idx_sel;
                last_q <= step.is_last;
            end
            if (rd_capture) rdata_q <= bus.data_out;
        end
    end

    flash_bus_cycle #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .WE_CYC (WE_CYC),
        .RD_CYC (RD_CYC)
    ) u_cycle (
        .clk          (SCL),
        .rst_n        (reset),
        .go           (go),
        .step_addr    (step_addr),
        .step_data    (step_data),
        .step_is_read (step.is_read),
        .ce_n         (ce_n),
        .we_n         (we_n),
        .oe_n         (oe_n),
        .dq_oe        (dq_oe),
        .mem_addr     (mem_addr),
        .wdata        (wdata),
        .rd_capture   (rd_capture),
        .cyc_end      (cyc_end),
        .state        (dbg_state)
    );

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.CE_N       = ce_n;
    assign bus.WE_N       = we_n;
    assign bus.OE_N       = oe_n;
    assign bus.dq_oe      = dq_oe;
    assign bus.mem_addr   = mem_addr;
    assign bus.DInDOut    = wdata;
    assign bus.shiftRegIn = rdata_q;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Directed testbench for flash_cmd_seq: default configuration plus a wide
// (DATA_W=16, ADDR_W=20, WE_CYC=4) instance.
module tb_flash_cmd_seq;
  import flash_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic SCL = 1'b0;
  logic reset = 1'b0;
  always #5 SCL = ~SCL;

  int cyc = 0;
  always @(posedge SCL) cyc <= cyc + 1;

  flash_cmd_seq_if #(.DATA_W(8), .ADDR_W(16)) bif();
  flash_cmd_seq_if #(.DATA_W(16), .ADDR_W(20)) wif();
  state_t dbg_state, wdbg_state;
  logic [7:0] rd_val = 8'h00;

  // Flash read model: drives rd_val only while chip and output are enabled
  assign bif.data_out = (!bif.CE_N && !bif.OE_N) ? rd_val : 8'h00;
  assign wif.data_out = 16'h0000;

  flash_cmd_seq #(.DATA_W(8), .ADDR_W(16), .WE_CYC(2), .RD_CYC(3)) dut (
    .SCL(SCL), .reset(reset), .bus(bif), .dbg_state(dbg_state)
  );

  flash_cmd_seq #(.DATA_W(16), .ADDR_W(20), .WE_CYC(4), .RD_CYC(3)) dut_w (
    .SCL(SCL), .reset(reset), .bus(wif), .dbg_state(wdbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- bus monitor (default instance) ----------------
  logic [15:0] mon_addr_q[$];
  logic [7:0]  mon_data_q[$];
  int          mon_w_q[$];
  logic [15:0] cur_a;
  logic [7:0]  cur_d;
  int          cur_w = 0;
  bit          in_pulse = 0;
  int          viol = 0, oe_low = 0, dq_high = 0, done_cnt = 0;

  always @(negedge SCL) begin
    if (!bif.WE_N) begin
      if (!in_pulse) begin
        in_pulse = 1; cur_w = 1; cur_a = bif.mem_addr; cur_d = bif.DInDOut;
      end else begin
        cur_w++;
      end
      if (!bif.dq_oe) viol++;
    end else if (in_pulse) begin
      in_pulse = 0;
      mon_addr_q.push_back(cur_a); mon_data_q.push_back(cur_d); mon_w_q.push_back(cur_w);
    end
    if (!bif.WE_N && !bif.OE_N) viol++;
    if (!bif.OE_N && bif.dq_oe) viol++;
    if (!bif.OE_N) oe_low++;
    if (bif.dq_oe) dq_high++;
    if (bif.done) done_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_a_q[$];
  logic [7:0]  exp_d_q[$];

  // ---------------- driver tasks ----------------
  task automatic mon_clear();
    #2;
    mon_addr_q.delete(); mon_data_q.delete(); mon_w_q.delete();
    viol = 0; oe_low = 0; dq_high = 0;
  endtask

  task automatic issue(input logic [1:0] c, input logic [15:0] a, input logic [7:0] d,
                       output int acc);
    @(negedge SCL);
    bif.start = 1'b1; bif.cmd = c; bif.addr = a; bif.shiftRegOut = d;
    @(posedge SCL); #1;
    acc = cyc;
    bif.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    bit ok;
    ok = 0; dc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge SCL);
      if (bif.done === 1'b1) begin dc = cyc; ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_done: done not seen within %0d cycles", budget); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bif.start = 0; bif.cmd = 0; bif.addr = 0; bif.shiftRegOut = 0;
    wif.start = 0; wif.cmd = 0; wif.addr = 0; wif.shiftRegOut = 0;
    reset = 1'b0;
    repeat (3) @(negedge SCL);
    checks++;
    if ({bif.CE_N, bif.WE_N, bif.OE_N, bif.busy, bif.done, bif.dq_oe} !== 6'b111000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 111000",
                         {bif.CE_N, bif.WE_N, bif.OE_N, bif.busy, bif.done, bif.dq_oe});
    end
    checks++;
    if (bif.mem_addr !== 16'h0 || bif.DInDOut !== 8'h0 || bif.shiftRegIn !== 8'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h expected 0000/00/00",
                         bif.mem_addr, bif.DInDOut, bif.shiftRegIn);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    checks++;
    if ({wif.CE_N, wif.WE_N, wif.OE_N, wif.busy, wif.done, wif.dq_oe} !== 6'b111000
        || wif.mem_addr !== 20'h0 || wif.DInDOut !== 16'h0) begin
      errors++; $display("FAIL reset_wide: got %b %h %h expected 111000 00000 0000",
                         {wif.CE_N, wif.WE_N, wif.OE_N, wif.busy, wif.done, wif.dq_oe},
                         wif.mem_addr, wif.DInDOut);
    end
    reset = 1'b1;
    repeat (2) @(negedge SCL);
    checks++;
    if (bif.busy !== 1'b0 || bif.CE_N !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: busy=%b CE_N=%b expected 0/1", bif.busy, bif.CE_N);
    end
  endtask

  task automatic test_program();
    int acc, dc, n;
    mon_clear();
    issue(2'b01, 16'h1234, 8'h5A, acc);
    checks++;
    if (bif.busy !== 1'b1) begin errors++; $display("FAIL prog_busy: got %b expected 1", bif.busy); end
    wait_done(60, dc);
    checks++;
    if (dc - acc !== 20) begin errors++; $display("FAIL prog_latency: got %0d expected 20", dc - acc); end
    checks++;
    if (bif.busy !== 1'b0) begin errors++; $display("FAIL prog_busy_done: got %b expected 0", bif.busy); end
    @(negedge SCL); #2;
    checks++;
    if (bif.done !== 1'b0) begin errors++; $display("FAIL prog_done_width: got %b expected 0", bif.done); end
    exp_a_q = '{16'h0555, 16'h02AA, 16'h0555, 16'h1234};
    exp_d_q = '{8'hAA, 8'h55, 8'hA0, 8'h5A};
    checks++;
    if (mon_addr_q.size() !== 4) begin errors++; $display("FAIL prog_count: got %0d expected 4", mon_addr_q.size()); end
    n = (mon_addr_q.size() < 4) ? mon_addr_q.size() : 4;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mon_addr_q[i] !== exp_a_q[i] || mon_data_q[i] !== exp_d_q[i] || mon_w_q[i] !== 2) begin
        errors++; $display("FAIL prog_write%0d: got %h/%h w%0d expected %h/%h w2",
                           i, mon_addr_q[i], mon_data_q[i], mon_w_q[i], exp_a_q[i], exp_d_q[i]);
      end
    end
    checks++;
    if (viol !== 0 || oe_low !== 0) begin errors++; $display("FAIL prog_invariants: viol=%0d oe_low=%0d expected 0/0", viol, oe_low); end
    checks++;
    if (bif.mem_addr !== 16'h1234 || bif.DInDOut !== 8'h5A) begin
      errors++; $display("FAIL prog_hold: got %h/%h expected 1234/5A", bif.mem_addr, bif.DInDOut);
    end
  endtask

  task automatic test_read();
    int acc, dc;
    mon_clear();
    rd_val = 8'hC3;
    issue(2'b00, 16'h00FF, 8'h00, acc);
    wait_done(60, dc);
    #2;
    checks++;
    if (dc - acc !== 5) begin errors++; $display("FAIL read_latency: got %0d expected 5", dc - acc); end
    checks++;
    if (oe_low !== 4) begin errors++; $display("FAIL read_oe_width: got %0d expected 4", oe_low); end
    checks++;
    if (mon_addr_q.size() !== 0 || dq_high !== 0 || viol !== 0) begin
      errors++; $display("FAIL read_no_drive: we_pulses=%0d dq_high=%0d viol=%0d expected 0/0/0",
                         mon_addr_q.size(), dq_high, viol);
    end
    checks++;
    if (bif.shiftRegIn !== 8'hC3) begin errors++; $display("FAIL read_data: got %h expected C3", bif.shiftRegIn); end
    checks++;
    if (bif.mem_addr !== 16'h00FF) begin errors++; $display("FAIL read_addr: got %h expected 00FF", bif.mem_addr); end
  endtask

  task automatic test_back_to_back();
    int acc1, dc1, acc2, dc2, n;
    mon_clear();
    rd_val = 8'h99;
    issue(2'b10, 16'h4000, 8'h00, acc1);
    wait_done(100, dc1);
    bif.start = 1'b1; bif.cmd = 2'b11; bif.addr = 16'hFFFF; bif.shiftRegOut = 8'hEE;
    @(posedge SCL); #1;
    acc2 = cyc;
    bif.start = 1'b0;
    checks++;
    if (bif.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b expected 1", bif.busy); end
    wait_done(60, dc2);
    #2;
    checks++;
    if (dc1 - acc1 !== 30) begin errors++; $display("FAIL erase_latency: got %0d expected 30", dc1 - acc1); end
    checks++;
    if (dc2 - dc1 !== 6) begin errors++; $display("FAIL b2b_gap: got %0d expected 6", dc2 - dc1); end
    exp_a_q = '{16'h0555, 16'h02AA, 16'h0555, 16'h0555, 16'h02AA, 16'h4000, 16'h0000};
    exp_d_q = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h30, 8'hF0};
    checks++;
    if (mon_addr_q.size() !== 7) begin errors++; $display("FAIL b2b_count: got %0d expected 7", mon_addr_q.size()); end
    n = (mon_addr_q.size() < 7) ? mon_addr_q.size() : 7;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mon_addr_q[i] !== exp_a_q[i] || mon_data_q[i] !== exp_d_q[i] || mon_w_q[i] !== 2) begin
        errors++; $display("FAIL b2b_write%0d: got %h/%h w%0d expected %h/%h w2",
                           i, mon_addr_q[i], mon_data_q[i], mon_w_q[i], exp_a_q[i], exp_d_q[i]);
      end
    end
    checks++;
    if (bif.shiftRegIn !== 8'hC3 || viol !== 0) begin
      errors++; $display("FAIL b2b_rdata_hold: got %h viol=%0d expected C3 viol=0", bif.shiftRegIn, viol);
    end
  endtask

  task automatic test_ignore_busy();
    int acc, dc, dbefore, n;
    mon_clear();
    dbefore = done_cnt;
    issue(2'b01, 16'h0ABC, 8'h3C, acc);
    repeat (6) @(negedge SCL);
    bif.start = 1'b1; bif.cmd = 2'b00; bif.addr = 16'h0111; bif.shiftRegOut = 8'hFF;
    @(negedge SCL);
    bif.start = 1'b0;
    repeat (8) @(negedge SCL);
    bif.start = 1'b1;
    @(negedge SCL);
    bif.start = 1'b0;
    wait_done(60, dc);
    checks++;
    if (dc - acc !== 20) begin errors++; $display("FAIL ign_latency: got %0d expected 20", dc - acc); end
    repeat (10) @(negedge SCL);
    #2;
    exp_a_q = '{16'h0555, 16'h02AA, 16'h0555, 16'h0ABC};
    exp_d_q = '{8'hAA, 8'h55, 8'hA0, 8'h3C};
    checks++;
    if (mon_addr_q.size() !== 4) begin errors++; $display("FAIL ign_count: got %0d expected 4", mon_addr_q.size()); end
    n = (mon_addr_q.size() < 4) ? mon_addr_q.size() : 4;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mon_addr_q[i] !== exp_a_q[i] || mon_data_q[i] !== exp_d_q[i]) begin
        errors++; $display("FAIL ign_write%0d: got %h/%h expected %h/%h",
                           i, mon_addr_q[i], mon_data_q[i], exp_a_q[i], exp_d_q[i]);
      end
    end
    checks++;
    if (done_cnt - dbefore !== 1 || oe_low !== 0 || bif.busy !== 1'b0) begin
      errors++; $display("FAIL ign_no_queue: dones=%0d oe_low=%0d busy=%b expected 1/0/0",
                         done_cnt - dbefore, oe_low, bif.busy);
    end
  endtask

  task automatic test_reset_mid();
    int acc, dc, dbefore, n;
    mon_clear();
    dbefore = done_cnt;
    issue(2'b01, 16'h1111, 8'h11, acc);
    repeat (7) @(negedge SCL);
    checks++;
    if (bif.WE_N !== 1'b0 || bif.mem_addr !== 16'h02AA) begin
      errors++; $display("FAIL rst_mid_pos: WE_N=%b addr=%h expected 0/02AA", bif.WE_N, bif.mem_addr);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({bif.CE_N, bif.WE_N, bif.OE_N, bif.busy, bif.done, bif.dq_oe} !== 6'b111000) begin
      errors++; $display("FAIL rst_mid_async: got %b expected 111000",
                         {bif.CE_N, bif.WE_N, bif.OE_N, bif.busy, bif.done, bif.dq_oe});
    end
    repeat (2) @(negedge SCL);
    reset = 1'b1;
    repeat (30) @(negedge SCL);
    #2;
    checks++;
    if (done_cnt !== dbefore || bif.busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rst_mid_abandon: dones=%0d busy=%b state=%0d expected 0/0/0",
                         done_cnt - dbefore, bif.busy, dbg_state);
    end
    mon_clear();
    issue(2'b01, 16'h2222, 8'h77, acc);
    wait_done(60, dc);
    #2;
    checks++;
    if (dc - acc !== 20) begin errors++; $display("FAIL rst_fresh_latency: got %0d expected 20", dc - acc); end
    exp_a_q = '{16'h0555, 16'h02AA, 16'h0555, 16'h2222};
    exp_d_q = '{8'hAA, 8'h55, 8'hA0, 8'h77};
    checks++;
    if (mon_addr_q.size() !== 4) begin errors++; $display("FAIL rst_fresh_count: got %0d expected 4", mon_addr_q.size()); end
    n = (mon_addr_q.size() < 4) ? mon_addr_q.size() : 4;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mon_addr_q[i] !== exp_a_q[i] || mon_data_q[i] !== exp_d_q[i] || mon_w_q[i] !== 2) begin
        errors++; $display("FAIL rst_fresh_write%0d: got %h/%h w%0d expected %h/%h w2",
                           i, mon_addr_q[i], mon_data_q[i], mon_w_q[i], exp_a_q[i], exp_d_q[i]);
      end
    end
  endtask

  task automatic test_wide();
    logic [19:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          ww_q[$];
    logic [19:0] ewa_q[$];
    logic [15:0] ewd_q[$];
    int acc, dc, w, n;
    bit inp, ok;
    inp = 0; ok = 0; w = 0; dc = 0;
    @(negedge SCL);
    wif.start = 1'b1; wif.cmd = 2'b01; wif.addr = 20'hABCDE; wif.shiftRegOut = 16'hBEEF;
    @(posedge SCL); #1;
    acc = cyc;
    wif.start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge SCL);
      if (!wif.WE_N) begin
        if (!inp) begin inp = 1; w = 1; wa_q.push_back(wif.mem_addr); wd_q.push_back(wif.DInDOut); end
        else w++;
      end else if (inp) begin
        inp = 0; ww_q.push_back(w);
      end
      if (wif.done === 1'b1) begin dc = cyc; ok = 1; break; end
    end
    checks++;
    if (!ok || dc - acc !== 28) begin
      errors++; $display("FAIL wide_latency: got %0d (seen=%0d) expected 28", dc - acc, ok);
    end
    ewa_q = '{20'h00555, 20'h002AA, 20'h00555, 20'hABCDE};
    ewd_q = '{16'h00AA, 16'h0055, 16'h00A0, 16'hBEEF};
    checks++;
    if (wa_q.size() !== 4 || ww_q.size() !== 4) begin
      errors++; $display("FAIL wide_count: got %0d/%0d expected 4", wa_q.size(), ww_q.size());
    end
    n = (ww_q.size() < 4) ? ww_q.size() : 4;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (wa_q[i] !== ewa_q[i] || wd_q[i] !== ewd_q[i] || ww_q[i] !== 4) begin
        errors++; $display("FAIL wide_write%0d: got %h/%h w%0d expected %h/%h w4",
                           i, wa_q[i], wd_q[i], ww_q[i], ewa_q[i], ewd_q[i]);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_program();
    test_read();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
